// File: rtl/hdmi_aux_scheduler.sv
// rtl/hdmi_aux_scheduler.sv - data-island packet slot arbiter for HDMI aux packet sources
// Optional frame statistics ports are enabled by defining HDMI_AUX_SCHED_STATS_EN.
module hdmi_aux_scheduler #(
  parameter int N_SRC        = 4,
  parameter int MAX_PER_LINE = 2,
  parameter int STARVE_LINES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             slot_start,
  input  logic             packet_end,
  input  logic             line_end,
`ifdef HDMI_AUX_SCHED_STATS_EN
  input  logic             frame_end,
  output logic [15:0]      pkt_frame,
  output logic [15:0]      drop_frame,
`endif
  output logic             aux_request,
  output logic [N_SRC-1:0] grant,
  output logic             busy,
  output logic [3:0]       line_count
);
  localparam int IW = (N_SRC > 2) ? $clog2(N_SRC) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [N_SRC-1:0]       grant_q, grant_d;
  logic [N_SRC-1:0]       granted_line_q, granted_line_d;
  logic                   aux_request_q, aux_request_d;
  logic                   busy_q, busy_d;
  logic [3:0]             line_count_q, line_count_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0][7:0]  starve_q, starve_d;

  logic [N_SRC-1:0] eligible;
  logic [IW-1:0]    sel_idx;
  logic             sel_found, sel_rr;
  logic             budget_ok, slot_eval, grant_issue;
  int               rr_idx;

  assign eligible    = req & ~grant_q;
  assign budget_ok   = line_count_q < 4'(MAX_PER_LINE);
  // packet_end frees the slot in the same cycle so a coincident slot_start can be granted
  assign slot_eval   = slot_start && ((state_q == IDLE) || packet_end);
  assign grant_issue = slot_eval && budget_ok && sel_found;

  // Later assignments override earlier ones: promoted > source 0 > round-robin
  always_comb begin
    sel_found = 1'b0;
    sel_rr    = 1'b0;
    sel_idx   = '0;
    rr_idx    = 0;
    for (int k = N_SRC - 2; k >= 0; k--) begin
      rr_idx = ((int'(rr_ptr_q) - 1 + k) % (N_SRC - 1)) + 1;
      if (eligible[rr_idx]) begin
        sel_found = 1'b1;
        sel_rr    = 1'b1;
        sel_idx   = IW'(rr_idx);
      end
    end
    if (eligible[0]) begin
      sel_found = 1'b1;
      sel_rr    = 1'b0;
      sel_idx   = '0;
    end
    for (int i = N_SRC - 1; i >= 1; i--) begin
      if (eligible[i] && (starve_q[i] >= 8'(STARVE_LINES))) begin
        sel_found = 1'b1;
        sel_rr    = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    busy_d         = busy_q;
    line_count_d   = line_count_q;
    rr_ptr_d       = rr_ptr_q;
    granted_line_d = line_end ? '0 : granted_line_q;
    aux_request_d  = budget_ok && (|eligible);

    if ((state_q == GRANT) && packet_end) begin
      state_d = IDLE;
      grant_d = '0;
      busy_d  = 1'b0;
    end

    if (grant_issue) begin
      state_d        = GRANT;
      grant_d        = N_SRC'(1) << sel_idx;
      busy_d         = 1'b1;
      granted_line_d = granted_line_d | grant_d;
      if (sel_rr) begin
        rr_ptr_d = (sel_idx == IW'(N_SRC - 1)) ? IW'(1) : sel_idx + 1'b1;
      end
    end

    // A grant on the line_end cycle is the first packet of the new line
    if (line_end) begin
      line_count_d = grant_issue ? 4'd1 : 4'd0;
    end else if (grant_issue) begin
      line_count_d = line_count_q + 4'd1;
    end

    for (int i = 0; i < N_SRC; i++) begin
      starve_d[i] = starve_q[i];
      if ((i == 0) || !req[i] || (grant_issue && grant_d[i])) begin
        starve_d[i] = '0;
      end else if (line_end && !granted_line_q[i] && (starve_q[i] != 8'hFF)) begin
        starve_d[i] = starve_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      aux_request_q  <= 1'b0;
      line_count_q   <= '0;
      rr_ptr_q       <= IW'(1);
      granted_line_q <= '0;
      starve_q       <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      aux_request_q  <= aux_request_d;
      line_count_q   <= line_count_d;
      rr_ptr_q       <= rr_ptr_d;
      granted_line_q <= granted_line_d;
      starve_q       <= starve_d;
    end
  end

  assign aux_request = aux_request_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign line_count  = line_count_q;

`ifdef HDMI_AUX_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] pkt_frame_q, pkt_frame_d;
  logic [15:0] drop_frame_q, drop_frame_d;

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    pkt_frame_d  = pkt_frame_q;
    drop_frame_d = drop_frame_q;
    if (grant_issue && (frame_cnt_q != 16'hFFFF)) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (frame_end) begin
      pkt_frame_d = frame_cnt_d;
      frame_cnt_d = '0;
    end
    if (slot_eval && !budget_ok && (|eligible) && (drop_frame_q != 16'hFFFF)) begin
      drop_frame_d = drop_frame_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      pkt_frame_q  <= '0;
      drop_frame_q <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      pkt_frame_q  <= pkt_frame_d;
      drop_frame_q <= drop_frame_d;
    end
  end

  assign pkt_frame  = pkt_frame_q;
  assign drop_frame = drop_frame_q;
`endif

endmodule

// File: tb/tb_hdmi_aux_scheduler.sv
// tb/tb_hdmi_aux_scheduler.sv - scoreboard bench for hdmi_aux_scheduler
// Directed stimulus pushes expected {grant, line_count}; a negedge monitor pops on each new grant.
module tb_hdmi_aux_scheduler;
  localparam int N = 4;

  logic         clk        = 1'b0;
  logic         reset      = 1'b1;
  logic [N-1:0] req        = '0;
  logic         slot_start = 1'b0;
  logic         packet_end = 1'b0;
  logic         line_end   = 1'b0;
  logic         aux_request;
  logic [N-1:0] grant;
  logic         busy;
  logic [3:0]   line_count;
`ifdef HDMI_AUX_SCHED_STATS_EN
  logic         frame_end  = 1'b0;
  logic [15:0]  pkt_frame;
  logic [15:0]  drop_frame;
`endif

  int total = 0;
  int bad   = 0;
  logic [7:0]   sb[$];
  logic [7:0]   exp_e;
  logic [N-1:0] prev_grant = '0;
  logic [3:0]   rr_seq[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};

  always #5 clk = ~clk;

  hdmi_aux_scheduler #(
    .N_SRC(N),
    .MAX_PER_LINE(2),
    .STARVE_LINES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .slot_start(slot_start),
    .packet_end(packet_end),
    .line_end(line_end),
`ifdef HDMI_AUX_SCHED_STATS_EN
    .frame_end(frame_end),
    .pkt_frame(pkt_frame),
    .drop_frame(drop_frame),
`endif
    .aux_request(aux_request),
    .grant(grant),
    .busy(busy),
    .line_count(line_count)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if ((grant !== prev_grant) && (grant !== '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", 16'(grant), 16'h0000);
      end else begin
        exp_e = sb.pop_front();
        check("grant", 16'(grant), 16'(exp_e[7:4]));
        check("grant_line_count", 16'(line_count), 16'(exp_e[3:0]));
      end
    end
    prev_grant = grant;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_slot(input logic [3:0] g, input logic [3:0] lc);
    sb.push_back({g, lc});
    slot_start = 1'b1;
    step(1);
    slot_start = 1'b0;
  endtask

  task automatic end_pkt();
    packet_end = 1'b1;
    step(1);
    packet_end = 1'b0;
  endtask

  task automatic end_line();
    line_end = 1'b1;
    step(1);
    line_end = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #3;
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_aux_request", 16'(aux_request), 16'h0);
    check("rst_line_count", 16'(line_count), 16'h0);
    step(2);
    reset = 1'b0;
    step(1);

    // single source, held through slot_start and req drop
    req = 4'b0001;
    step(2);
    check("aux_request_up", 16'(aux_request), 16'h1);
    do_slot(4'b0001, 4'd1);
    check("busy_on_grant", 16'(busy), 16'h1);
    req = 4'b0000;
    slot_start = 1'b1;
    step(1);
    slot_start = 1'b0;
    step(1);
    check("grant_held", 16'(grant), 16'h1);
    check("line_count_held", 16'(line_count), 16'h1);
    end_pkt();
    check("grant_cleared", 16'(grant), 16'h0);
    check("busy_cleared", 16'(busy), 16'h0);
    end_line();
    check("line_count_cleared", 16'(line_count), 16'h0);

    // round-robin wrap, one slot per line
    req = 4'b1110;
    step(2);
    for (int l = 0; l < 4; l++) begin
      do_slot(rr_seq[l], 4'd1);
      step(1);
      end_pkt();
      end_line();
    end
    req = 4'b0000;
    step(2);

    // per-line budget
    req = 4'b0011;
    step(2);
    do_slot(4'b0001, 4'd1);
    end_pkt();
    do_slot(4'b0001, 4'd2);
    end_pkt();
    check("aux_request_budget", 16'(aux_request), 16'h0);
    slot_start = 1'b1;
    step(1);
    slot_start = 1'b0;
    check("no_third_grant", 16'(grant), 16'h0);
    check("budget_line_count", 16'(line_count), 16'h2);
    end_line();
    check("budget_line_cleared", 16'(line_count), 16'h0);
    step(1);
    check("aux_request_new_line", 16'(aux_request), 16'h1);
    req = 4'b0000;
    step(2);

    // grant coincident with line_end counts as first of next line
    req = 4'b0001;
    step(1);
    do_slot(4'b0001, 4'd1);
    end_pkt();
    sb.push_back({4'b0001, 4'd1});
    slot_start = 1'b1;
    line_end   = 1'b1;
    step(1);
    slot_start = 1'b0;
    line_end   = 1'b0;
    check("line_end_grant_count", 16'(line_count), 16'h1);
    end_pkt();
    end_line();
    req = 4'b0000;
    step(2);

    // starvation promotion of source 2 over source 0
    req = 4'b0101;
    step(1);
    for (int l = 1; l <= 5; l++) begin
      do_slot((l == 4) ? 4'b0100 : 4'b0001, 4'd1);
      step(1);
      end_pkt();
      end_line();
    end
    req = 4'b0000;
    step(2);

    // back-to-back grant on packet_end + slot_start
    req = 4'b0110;
    step(1);
    do_slot(4'b0010, 4'd1);
    step(2);
    sb.push_back({4'b0100, 4'd2});
    packet_end = 1'b1;
    slot_start = 1'b1;
    step(1);
    packet_end = 1'b0;
    slot_start = 1'b0;
    check("b2b_grant", 16'(grant), 16'h4);
    check("b2b_busy", 16'(busy), 16'h1);
    end_pkt();
    end_line();

    // asynchronous reset mid-grant, rr_ptr back to 1
    do_slot(4'b0010, 4'd1);
    step(1);
    reset = 1'b1;
    #1;
    check("async_rst_grant", 16'(grant), 16'h0);
    check("async_rst_busy", 16'(busy), 16'h0);
    check("async_rst_aux_request", 16'(aux_request), 16'h0);
    step(1);
    reset = 1'b0;
    check("post_rst_line_count", 16'(line_count), 16'h0);
    req = 4'b1010;
    step(2);
    do_slot(4'b0010, 4'd1);
    end_pkt();
    req = 4'b0000;
    step(4);

    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
